// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and write-port record for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rf_wr_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Registered synchronous FIFO with head read; no bypass from push to head.
module rf_wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    cnt_q;

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop_i) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign head_o = mem_q[rd_ptr_q];
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between pipeline WB and buffered MDU results,
// and tracks MDU destinations in a scoreboard that drives the decode stall.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::rf_wr_t;
#(
   parameter int DATA_W     = rf_wb_arbiter_pkg::DATA_W,
   parameter int ADDR_W     = rf_wb_arbiter_pkg::ADDR_W,
   parameter int FIFO_DEPTH = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          wb_valid,
   input  logic [ADDR_W-1:0]             wb_addr,
   input  logic [DATA_W-1:0]             wb_data,
   input  logic                          mdu_valid,
   output logic                          mdu_ready,
   input  logic [ADDR_W-1:0]             mdu_addr,
   input  logic [DATA_W-1:0]             mdu_data,
   input  logic [ADDR_W-1:0]             dec_rs,
   input  logic [ADDR_W-1:0]             dec_rt,
   input  logic [ADDR_W-1:0]             dec_rd,
   input  logic                          dec_rd_we,
   input  logic                          iss_valid,
   input  logic [ADDR_W-1:0]             iss_addr,
   output logic                          stall,
   output logic                          rf_we,
   output logic [ADDR_W-1:0]             rf_waddr,
   output logic [DATA_W-1:0]             rf_wdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

   localparam int NREG = 1 << ADDR_W;
   localparam int CW   = $clog2(FIFO_DEPTH) + 1;
   localparam int SW   = $clog2(STARVE_MAX + 1);

   logic [NREG-1:1]          busy_q, busy_d;
   logic [NREG-1:0]          busy_v;
   logic [SW-1:0]            starve_q, starve_d;
   logic [ADDR_W+DATA_W-1:0] head;
   logic [ADDR_W-1:0]        head_addr;
   logic [DATA_W-1:0]        head_data;
   logic                     fifo_empty;
   logic                     push;
   logic                     pop;
   logic                     issue;
   rf_wr_t                   wr;

   rf_wb_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (clk),
      .rst_i  (reset),
      .push_i (push),
      .data_i ({mdu_addr, mdu_data}),
      .pop_i  (pop),
      .head_o (head),
      .cnt_o  (fifo_cnt)
   );

   assign {head_addr, head_data} = head;
   assign busy_v     = {busy_q, 1'b0};
   assign fifo_empty = (fifo_cnt == '0);
   // Ready looks only at the registered count, so a full FIFO never accepts
   // a push in the same cycle it pops.
   assign mdu_ready  = (fifo_cnt < CW'(FIFO_DEPTH));
   assign push       = mdu_valid & mdu_ready;
   assign pop        = !wb_valid && !fifo_empty;

   always_comb begin
      wr = '0;
      if (!reset) begin
         if (wb_valid) begin
            wr.we   = (wb_addr != '0);
            wr.addr = wb_addr;
            wr.data = wb_data;
         end else if (!fifo_empty) begin
            wr.we   = (head_addr != '0);
            wr.addr = head_addr;
            wr.data = head_data;
         end
      end
   end

   assign rf_we    = wr.we;
   assign rf_waddr = wr.addr;
   assign rf_wdata = wr.data;

   assign stall = !reset && (busy_v[dec_rs] || busy_v[dec_rt] ||
                             (dec_rd_we && busy_v[dec_rd]) ||
                             (iss_valid && busy_v[iss_addr]) ||
                             (starve_q == SW'(STARVE_MAX)));
   assign issue = iss_valid && !stall && (iss_addr != '0);

   always_comb begin
      busy_d = busy_q;
      if (pop && (head_addr != '0)) begin
         busy_d[head_addr] = 1'b0;
      end
      if (issue) begin
         busy_d[iss_addr] = 1'b1;
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (pop) begin
         starve_d = '0;
      end else if (wb_valid && !fifo_empty && (starve_q != SW'(STARVE_MAX))) begin
         starve_d = starve_q + SW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q   <= '0;
         starve_q <= '0;
      end else begin
         busy_q   <= busy_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: write-port scoreboard plus stall/FIFO checks.
module tb_rf_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wb_valid, mdu_valid, mdu_ready, dec_rd_we, iss_valid;
   logic [AW-1:0] wb_addr, mdu_addr, dec_rs, dec_rt, dec_rd, iss_addr;
   logic [DW-1:0] wb_data, mdu_data;
   logic          stall, rf_we;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [1:0]    fifo_cnt;

   int checks = 0;
   int failures = 0;

   logic [AW+DW-1:0] wb_exp_q[$];
   logic [AW+DW-1:0] mdu_exp_q[$];

   rf_wb_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .wb_valid  (wb_valid),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .mdu_valid (mdu_valid),
      .mdu_ready (mdu_ready),
      .mdu_addr  (mdu_addr),
      .mdu_data  (mdu_data),
      .dec_rs    (dec_rs),
      .dec_rt    (dec_rt),
      .dec_rd    (dec_rd),
      .dec_rd_we (dec_rd_we),
      .iss_valid (iss_valid),
      .iss_addr  (iss_addr),
      .stall     (stall),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .fifo_cnt  (fifo_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      wb_valid = 0; wb_addr = '0; wb_data = '0;
      mdu_valid = 0; mdu_addr = '0; mdu_data = '0;
      dec_rs = '0; dec_rt = '0; dec_rd = '0; dec_rd_we = 0;
      iss_valid = 0; iss_addr = '0;
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_wb(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
      wb_valid = 1; wb_addr = a; wb_data = d;
      if (expect_write) wb_exp_q.push_back({a, d});
   endtask

   task automatic drive_mdu(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
      mdu_valid = 1; mdu_addr = a; mdu_data = d;
      if (expect_write) mdu_exp_q.push_back({a, d});
   endtask

   // Monitor: every write the DUT presents is matched against the source queue.
   always @(negedge clk) begin
      if (!reset && rf_we) begin
         if (wb_valid) begin
            if (wb_exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL wb_write: got 0x%0h expected none", {rf_waddr, rf_wdata});
            end else begin
               check("wb_write", {rf_waddr, rf_wdata}, wb_exp_q.pop_front());
            end
         end else begin
            if (mdu_exp_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL mdu_write: got 0x%0h expected none", {rf_waddr, rf_wdata});
            end else begin
               check("mdu_write", {rf_waddr, rf_wdata}, mdu_exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      idle();
      reset = 1;
      repeat (2) @(posedge clk);
      #1 drive_wb(5'd3, 32'h33, 1'b0);
      @(negedge clk);
      check("rst_fifo_cnt", fifo_cnt, 0);
      check("rst_mdu_ready", mdu_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_rf_we", rf_we, 0);

      // WB only
      drive_edge(); reset = 0; drive_wb(5'd5, 32'h1234, 1'b1);
      @(negedge clk); check("wb_we", rf_we, 1);
      drive_edge(); drive_wb(5'd0, 32'hDEAD, 1'b0);
      @(negedge clk); check("wb_addr0_we", rf_we, 0);

      // MDU reservation and completion
      drive_edge(); wb_valid = 0; iss_valid = 1; iss_addr = 5'd8;
      @(negedge clk); check("iss_stall_same_cycle", stall, 0);
      drive_edge(); iss_valid = 0; dec_rs = 5'd8;
      @(negedge clk); check("raw_rs_stall", stall, 1);
      drive_edge(); drive_mdu(5'd8, 32'hBEEF, 1'b1);
      @(negedge clk); check("mdu_ready_empty", mdu_ready, 1); check("raw_stall_push", stall, 1);
      drive_edge(); mdu_valid = 0;
      @(negedge clk); check("mdu_cnt1", fifo_cnt, 1); check("mdu_we", rf_we, 1); check("stall_pop_cycle", stall, 1);
      drive_edge();
      @(negedge clk); check("stall_released", stall, 0); check("mdu_cnt0", fifo_cnt, 0);
      dec_rs = '0;

      // Contention: WB holds the port while the FIFO fills
      for (int i = 0; i < 3; i++) begin
         drive_edge();
         drive_wb(AW'(i + 1), 32'hA0 + i, 1'b1);
         if (i < 2) drive_mdu(AW'(9 + i), 32'h99 + i, 1'b1);
         else mdu_valid = 0;
         @(negedge clk);
         if (i == 1) check("cont_ready_half", mdu_ready, 1);
         if (i == 2) begin
            check("cont_ready_full", mdu_ready, 0);
            check("cont_cnt_full", fifo_cnt, 2);
         end
      end
      drive_edge(); wb_valid = 0;
      @(negedge clk); check("drain1_we", rf_we, 1); check("drain1_addr", rf_waddr, 9);
      drive_edge();
      @(negedge clk); check("drain2_addr", rf_waddr, 10); check("drain2_cnt", fifo_cnt, 1);
      drive_edge();
      @(negedge clk); check("drain_done_cnt", fifo_cnt, 0); check("drain_done_we", rf_we, 0);

      // Starvation
      for (int i = 0; i < 6; i++) begin
         drive_edge();
         drive_wb(5'd4, 32'h4000 + i, 1'b1);
         if (i == 0) drive_mdu(5'd11, 32'h1111, 1'b1);
         else mdu_valid = 0;
         @(negedge clk);
         if (i == 4) check("starve_not_yet", stall, 0);
         if (i == 5) check("starve_stall", stall, 1);
      end
      drive_edge(); wb_valid = 0;
      @(negedge clk); check("starve_pop_stall", stall, 1); check("starve_pop_addr", rf_waddr, 11);
      drive_edge();
      @(negedge clk); check("starve_cleared", stall, 0);

      // Hazards
      drive_edge(); iss_valid = 1; iss_addr = 5'd0;
      @(negedge clk); check("iss0_stall", stall, 0);
      drive_edge();
      @(negedge clk); check("iss0_no_busy", stall, 0);
      drive_edge(); iss_addr = 5'd8;
      @(negedge clk); check("iss8_stall", stall, 0);
      drive_edge(); iss_valid = 0; dec_rd = 5'd8; dec_rd_we = 0;
      @(negedge clk); check("rd_no_we_stall", stall, 0);
      drive_edge(); dec_rd_we = 1;
      @(negedge clk); check("waw_stall", stall, 1);
      drive_edge(); dec_rd_we = 0; dec_rt = 5'd8;
      @(negedge clk); check("raw_rt_stall", stall, 1);
      drive_edge(); dec_rt = '0; iss_valid = 1; iss_addr = 5'd8;
      @(negedge clk); check("iss_busy_stall", stall, 1);

      // Reset with pending results and a reservation
      drive_edge(); iss_valid = 0; drive_wb(5'd6, 32'h600, 1'b1); drive_mdu(5'd12, 32'hC, 1'b0);
      drive_edge(); drive_wb(5'd6, 32'h601, 1'b1); drive_mdu(5'd13, 32'hD, 1'b0);
      drive_edge(); mdu_valid = 0; drive_wb(5'd6, 32'h602, 1'b1); dec_rs = 5'd8;
      @(negedge clk); check("pre_rst_cnt", fifo_cnt, 2); check("pre_rst_stall", stall, 1);
      drive_edge(); reset = 1; drive_wb(5'd6, 32'h603, 1'b0);
      @(negedge clk);
      check("mid_rst_we", rf_we, 0); check("mid_rst_cnt", fifo_cnt, 0);
      check("mid_rst_stall", stall, 0); check("mid_rst_ready", mdu_ready, 1);
      drive_edge(); reset = 0; wb_valid = 0;
      @(negedge clk);
      check("post_rst_busy", stall, 0); check("post_rst_cnt", fifo_cnt, 0); check("post_rst_we", rf_we, 0);

      check("wb_queue_empty", wb_exp_q.size(), 0);
      check("mdu_queue_empty", mdu_exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
